// File: rtl/rs_bank.sv
// ============================================================================
// rs_bank : multi-entry reservation station with CDB wakeup and FU issue port
// Optional macro RS_AGE_SELECT_EN: oldest-ready issue instead of lowest index.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rs_bank #(
  parameter int RS_DEPTH  = 8,
  parameter int DP_W      = 3,
  parameter int CDB_W     = 3,
  parameter int TAG_W     = 3,
  parameter int XLEN      = 32,
  parameter int PAYLOAD_W = 64
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          clear,
  input  logic [DP_W-1:0]               dp_valid,
  input  logic [DP_W*PAYLOAD_W-1:0]     dp_payload,
  input  logic [DP_W*TAG_W-1:0]         dp_T,
  input  logic [DP_W*TAG_W-1:0]         dp_T1,
  input  logic [DP_W*TAG_W-1:0]         dp_T2,
  input  logic [DP_W-1:0]               dp_rdy1,
  input  logic [DP_W-1:0]               dp_rdy2,
  input  logic [DP_W*XLEN-1:0]          dp_V1,
  input  logic [DP_W*XLEN-1:0]          dp_V2,
  input  logic [CDB_W-1:0]              cdb_valid,
  input  logic [CDB_W*TAG_W-1:0]        cdb_tag,
  input  logic [CDB_W*XLEN-1:0]         cdb_value,
  input  logic                          iss_ready,
  output logic                          iss_valid,
  output logic [PAYLOAD_W-1:0]          iss_payload,
  output logic [TAG_W-1:0]              iss_T,
  output logic [XLEN-1:0]               iss_V1,
  output logic [XLEN-1:0]               iss_V2,
  output logic [$clog2(RS_DEPTH+1)-1:0] free_cnt,
  output logic                          dp_overflow
);

  localparam int IDX_W  = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;
  localparam int CNT_W  = $clog2(RS_DEPTH + 1);
  localparam int SLOT_W = (DP_W > 1) ? $clog2(DP_W) : 1;

  logic [RS_DEPTH-1:0]  r_valid;
  logic [RS_DEPTH-1:0]  r_rdy1;
  logic [RS_DEPTH-1:0]  r_rdy2;
  logic [PAYLOAD_W-1:0] r_payload [RS_DEPTH];
  logic [TAG_W-1:0]     r_T       [RS_DEPTH];
  logic [TAG_W-1:0]     r_T1      [RS_DEPTH];
  logic [TAG_W-1:0]     r_T2      [RS_DEPTH];
  logic [XLEN-1:0]      r_V1      [RS_DEPTH];
  logic [XLEN-1:0]      r_V2      [RS_DEPTH];
  logic                 r_hold;
  logic [IDX_W-1:0]     r_hold_idx;
  logic [CNT_W-1:0]     r_free_cnt;
  logic                 r_overflow;

  logic [RS_DEPTH-1:0]  w_ready;
  logic                 w_found_sel;
  logic [IDX_W-1:0]     w_pick;
  logic [IDX_W-1:0]     w_sel;
  logic                 w_fire;

  logic [RS_DEPTH-1:0]  w_taken;
  logic                 w_found_alloc;
  logic [RS_DEPTH-1:0]  w_ent_wr;
  logic [SLOT_W-1:0]    w_ent_slot [RS_DEPTH];
  logic [CNT_W-1:0]     w_slot_ord [DP_W];
  logic [CNT_W-1:0]     w_n_acc;
  logic                 w_drop;

  logic [XLEN:0]        w_wk1  [RS_DEPTH];
  logic [XLEN:0]        w_wk2  [RS_DEPTH];
  logic [XLEN:0]        w_dop1 [DP_W];
  logic [XLEN:0]        w_dop2 [DP_W];

`ifdef RS_AGE_SELECT_EN
  logic [IDX_W-1:0]     r_age [RS_DEPTH];
  logic [IDX_W-1:0]     w_best_age;
  logic [CNT_W-1:0]     w_base;
`endif

  // Returns {hit, value}; scanning downwards lets the lowest matching channel win.
  function automatic logic [XLEN:0] cdb_lookup(input logic [TAG_W-1:0] tag);
    logic [XLEN:0] res;
    res = '0;
    for (int c = CDB_W - 1; c >= 0; c--) begin
      if (cdb_valid[c] && (cdb_tag[c*TAG_W +: TAG_W] == tag))
        res = {1'b1, cdb_value[c*XLEN +: XLEN]};
    end
    return res;
  endfunction

  always_comb begin
    for (int e = 0; e < RS_DEPTH; e++) begin
      w_wk1[e] = cdb_lookup(r_T1[e]);
      w_wk2[e] = cdb_lookup(r_T2[e]);
    end
    for (int k = 0; k < DP_W; k++) begin
      w_dop1[k] = dp_rdy1[k] ? {1'b1, dp_V1[k*XLEN +: XLEN]} : cdb_lookup(dp_T1[k*TAG_W +: TAG_W]);
      w_dop2[k] = dp_rdy2[k] ? {1'b1, dp_V2[k*XLEN +: XLEN]} : cdb_lookup(dp_T2[k*TAG_W +: TAG_W]);
    end
  end

  // Issue selection; a stalled presentation is pinned via r_hold_idx.
  always_comb begin
    w_ready     = r_valid & r_rdy1 & r_rdy2;
    w_found_sel = 1'b0;
    w_pick      = '0;
`ifdef RS_AGE_SELECT_EN
    w_best_age  = '0;
    for (int e = 0; e < RS_DEPTH; e++) begin
      if (w_ready[e] && (!w_found_sel || (r_age[e] < w_best_age))) begin
        w_found_sel = 1'b1;
        w_pick      = IDX_W'(e);
        w_best_age  = r_age[e];
      end
    end
`else
    for (int e = 0; e < RS_DEPTH; e++) begin
      if (w_ready[e] && !w_found_sel) begin
        w_found_sel = 1'b1;
        w_pick      = IDX_W'(e);
      end
    end
`endif
    w_sel = r_hold ? r_hold_idx : w_pick;
  end

  assign iss_valid   = |w_ready;
  assign w_fire      = iss_valid & iss_ready;
  assign iss_payload = r_payload[w_sel];
  assign iss_T       = r_T[w_sel];
  assign iss_V1      = r_V1[w_sel];
  assign iss_V2      = r_V2[w_sel];
  assign free_cnt    = r_free_cnt;
  assign dp_overflow = r_overflow;

  // Greedy in-order allocation: slot k takes the lowest free entry left over.
  always_comb begin
    w_taken  = '0;
    w_ent_wr = '0;
    w_n_acc  = '0;
    w_drop   = 1'b0;
    w_found_alloc = 1'b0;
    for (int e = 0; e < RS_DEPTH; e++) w_ent_slot[e] = '0;
    for (int k = 0; k < DP_W; k++) begin
      w_slot_ord[k] = w_n_acc;
      w_found_alloc = 1'b0;
      if (dp_valid[k]) begin
        for (int e = 0; e < RS_DEPTH; e++) begin
          if (!r_valid[e] && !w_taken[e] && !w_found_alloc) begin
            w_found_alloc = 1'b1;
            w_taken[e]    = 1'b1;
            w_ent_wr[e]   = 1'b1;
            w_ent_slot[e] = SLOT_W'(k);
          end
        end
        if (w_found_alloc) w_n_acc = w_n_acc + CNT_W'(1);
        else               w_drop  = 1'b1;
      end
    end
  end

`ifdef RS_AGE_SELECT_EN
  // Occupancy left after this cycle's issue; new ops rank behind it in slot order.
  assign w_base = CNT_W'(RS_DEPTH) - r_free_cnt - CNT_W'(w_fire);
`endif

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      r_valid    <= '0;
      r_hold     <= 1'b0;
      r_hold_idx <= '0;
      r_free_cnt <= CNT_W'(RS_DEPTH);
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= w_drop;
      r_free_cnt <= r_free_cnt - w_n_acc + CNT_W'(w_fire);
      r_hold     <= iss_valid & ~iss_ready;
      if (iss_valid && !iss_ready) r_hold_idx <= w_sel;
      for (int e = 0; e < RS_DEPTH; e++) begin
        if (w_fire && (w_sel == IDX_W'(e))) r_valid[e] <= 1'b0;
        if (r_valid[e] && !r_rdy1[e] && w_wk1[e][XLEN]) begin
          r_rdy1[e] <= 1'b1;
          r_V1[e]   <= w_wk1[e][XLEN-1:0];
        end
        if (r_valid[e] && !r_rdy2[e] && w_wk2[e][XLEN]) begin
          r_rdy2[e] <= 1'b1;
          r_V2[e]   <= w_wk2[e][XLEN-1:0];
        end
`ifdef RS_AGE_SELECT_EN
        if (w_fire && r_valid[e] && (r_age[e] > r_age[w_sel])) r_age[e] <= r_age[e] - IDX_W'(1);
`endif
        if (w_ent_wr[e]) begin
          r_valid[e]   <= 1'b1;
          r_payload[e] <= dp_payload[w_ent_slot[e]*PAYLOAD_W +: PAYLOAD_W];
          r_T[e]       <= dp_T[w_ent_slot[e]*TAG_W +: TAG_W];
          r_T1[e]      <= dp_T1[w_ent_slot[e]*TAG_W +: TAG_W];
          r_T2[e]      <= dp_T2[w_ent_slot[e]*TAG_W +: TAG_W];
          r_rdy1[e]    <= w_dop1[w_ent_slot[e]][XLEN];
          r_rdy2[e]    <= w_dop2[w_ent_slot[e]][XLEN];
          r_V1[e]      <= w_dop1[w_ent_slot[e]][XLEN-1:0];
          r_V2[e]      <= w_dop2[w_ent_slot[e]][XLEN-1:0];
`ifdef RS_AGE_SELECT_EN
          r_age[e]     <= IDX_W'(w_base + w_slot_ord[w_ent_slot[e]]);
`endif
        end
      end
    end
  end

`ifndef RS_AGE_SELECT_EN
  // Slot order only feeds age ranking.
  logic w_unused_ord;
  always_comb begin
    w_unused_ord = 1'b0;
    for (int k = 0; k < DP_W; k++) w_unused_ord = w_unused_ord ^ (^w_slot_ord[k]);
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_rs_bank.sv
// ============================================================================
// tb_rs_bank : directed self-checking bench for rs_bank
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_rs_bank;

  logic          clock = 1'b0;
  logic          reset, clear;
  logic [2:0]    dp_valid;
  logic [191:0]  dp_payload;
  logic [8:0]    dp_T, dp_T1, dp_T2;
  logic [2:0]    dp_rdy1, dp_rdy2;
  logic [95:0]   dp_V1, dp_V2;
  logic [2:0]    cdb_valid;
  logic [8:0]    cdb_tag;
  logic [95:0]   cdb_value;
  logic          iss_ready;
  logic          iss_valid;
  logic [63:0]   iss_payload;
  logic [2:0]    iss_T;
  logic [31:0]   iss_V1, iss_V2;
  logic [3:0]    free_cnt;
  logic          dp_overflow;

  int n_checks = 0;
  int n_fail   = 0;

  rs_bank dut (
    .clock(clock), .reset(reset), .clear(clear),
    .dp_valid(dp_valid), .dp_payload(dp_payload), .dp_T(dp_T),
    .dp_T1(dp_T1), .dp_T2(dp_T2), .dp_rdy1(dp_rdy1), .dp_rdy2(dp_rdy2),
    .dp_V1(dp_V1), .dp_V2(dp_V2),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .iss_ready(iss_ready), .iss_valid(iss_valid), .iss_payload(iss_payload),
    .iss_T(iss_T), .iss_V1(iss_V1), .iss_V2(iss_V2),
    .free_cnt(free_cnt), .dp_overflow(dp_overflow)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    dp_valid  = '0;
    cdb_valid = '0;
  endtask

  task automatic set_slot(input int k, input logic [63:0] pl, input logic [2:0] t,
                          input logic [2:0] t1, input logic r1, input logic [31:0] v1,
                          input logic [2:0] t2, input logic r2, input logic [31:0] v2);
    dp_valid[k]            = 1'b1;
    dp_payload[k*64 +: 64] = pl;
    dp_T[k*3 +: 3]         = t;
    dp_T1[k*3 +: 3]        = t1;
    dp_rdy1[k]             = r1;
    dp_V1[k*32 +: 32]      = v1;
    dp_T2[k*3 +: 3]        = t2;
    dp_rdy2[k]             = r2;
    dp_V2[k*32 +: 32]      = v2;
  endtask

  task automatic set_cdb(input int c, input logic [2:0] tag, input logic [31:0] val);
    cdb_valid[c]           = 1'b1;
    cdb_tag[c*3 +: 3]      = tag;
    cdb_value[c*32 +: 32]  = val;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    n_checks++; if (free_cnt !== 4'd8) begin n_fail++; $display("FAIL reset_free_cnt got %0d expected 8", free_cnt); end
    n_checks++; if (iss_valid !== 1'b0) begin n_fail++; $display("FAIL reset_iss_valid got %b expected 0", iss_valid); end
    n_checks++; if (dp_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %b expected 0", dp_overflow); end
  endtask

  task automatic test_ready_dispatch();
    set_slot(0, 64'hDEAD_BEEF_0000_0001, 3'd3, 3'd0, 1'b1, 32'd1, 3'd0, 1'b1, 32'd2);
    step();
    idle();
    n_checks++; if (iss_valid !== 1'b1) begin n_fail++; $display("FAIL rd_iss_valid got %b expected 1", iss_valid); end
    n_checks++; if (iss_T !== 3'd3) begin n_fail++; $display("FAIL rd_iss_T got %0d expected 3", iss_T); end
    n_checks++; if (iss_V1 !== 32'd1 || iss_V2 !== 32'd2) begin n_fail++; $display("FAIL rd_values got %0h/%0h expected 1/2", iss_V1, iss_V2); end
    n_checks++; if (iss_payload !== 64'hDEAD_BEEF_0000_0001) begin n_fail++; $display("FAIL rd_payload got %0h expected deadbeef00000001", iss_payload); end
    n_checks++; if (free_cnt !== 4'd7) begin n_fail++; $display("FAIL rd_free_cnt got %0d expected 7", free_cnt); end
    iss_ready = 1'b1;
    step();
    iss_ready = 1'b0;
    n_checks++; if (free_cnt !== 4'd8) begin n_fail++; $display("FAIL rd_free_after got %0d expected 8", free_cnt); end
    n_checks++; if (iss_valid !== 1'b0) begin n_fail++; $display("FAIL rd_empty got %b expected 0", iss_valid); end
  endtask

  task automatic test_cdb_wakeup();
    iss_ready = 1'b1;
    set_slot(0, 64'h2, 3'd1, 3'd7, 1'b0, 32'd0, 3'd0, 1'b1, 32'hFFFF_FFFF);
    step();
    idle();
    n_checks++; if (iss_valid !== 1'b0) begin n_fail++; $display("FAIL wk_not_ready got %b expected 0", iss_valid); end
    // channel 1 and 2 both match; channel 1 must win
    set_cdb(1, 3'd7, 32'hF);
    set_cdb(2, 3'd7, 32'h55);
    set_cdb(0, 3'd4, 32'h99);
    n_checks++; if (iss_valid !== 1'b0) begin n_fail++; $display("FAIL wk_no_bypass got %b expected 0", iss_valid); end
    step();
    idle();
    n_checks++; if (iss_valid !== 1'b1 || iss_T !== 3'd1) begin n_fail++; $display("FAIL wk_issue got v=%b T=%0d expected v=1 T=1", iss_valid, iss_T); end
    n_checks++; if (iss_V1 !== 32'hF || iss_V2 !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wk_values got %0h/%0h expected f/ffffffff", iss_V1, iss_V2); end
    step();
    iss_ready = 1'b0;
    n_checks++; if (free_cnt !== 4'd8 || iss_valid !== 1'b0) begin n_fail++; $display("FAIL wk_drain got cnt=%0d v=%b expected 8/0", free_cnt, iss_valid); end
  endtask

  task automatic test_dispatch_capture();
    set_slot(0, 64'h3, 3'd2, 3'd5, 1'b0, 32'd0, 3'd0, 1'b1, 32'd7);
    set_cdb(0, 3'd5, 32'hA);
    step();
    idle();
    n_checks++; if (iss_valid !== 1'b1 || iss_T !== 3'd2) begin n_fail++; $display("FAIL cap_issue got v=%b T=%0d expected v=1 T=2", iss_valid, iss_T); end
    n_checks++; if (iss_V1 !== 32'hA || iss_V2 !== 32'd7) begin n_fail++; $display("FAIL cap_values got %0h/%0h expected a/7", iss_V1, iss_V2); end
    iss_ready = 1'b1;
    step();
    iss_ready = 1'b0;
    n_checks++; if (free_cnt !== 4'd8) begin n_fail++; $display("FAIL cap_free got %0d expected 8", free_cnt); end
  endtask

  task automatic test_overflow();
    for (int g = 0; g < 3; g++) begin
      for (int k = 0; k < 3; k++) begin
        if (g * 3 + k < 8)
          set_slot(k, 64'(g * 3 + k), 3'(g * 3 + k), 3'(g * 3 + k), 1'b0, 32'd0, 3'd0, 1'b1, 32'd0);
      end
      step();
      idle();
    end
    n_checks++; if (free_cnt !== 4'd0 || dp_overflow !== 1'b0) begin n_fail++; $display("FAIL ov_full got cnt=%0d ovf=%b expected 0/0", free_cnt, dp_overflow); end
    set_slot(0, 64'hE0, 3'd6, 3'd0, 1'b1, 32'd0, 3'd0, 1'b1, 32'd0);
    set_slot(1, 64'hE1, 3'd7, 3'd0, 1'b1, 32'd0, 3'd0, 1'b1, 32'd0);
    step();
    idle();
    n_checks++; if (dp_overflow !== 1'b1 || free_cnt !== 4'd0) begin n_fail++; $display("FAIL ov_pulse got ovf=%b cnt=%0d expected 1/0", dp_overflow, free_cnt); end
    n_checks++; if (iss_valid !== 1'b0) begin n_fail++; $display("FAIL ov_dropped_issue got %b expected 0", iss_valid); end
    step();
    n_checks++; if (dp_overflow !== 1'b0) begin n_fail++; $display("FAIL ov_one_cycle got %b expected 0", dp_overflow); end
    iss_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (c < 3) begin
        for (int ch = 0; ch < 3; ch++) begin
          if (c * 3 + ch < 8) set_cdb(ch, 3'(c * 3 + ch), 32'h100 + 32'(c * 3 + ch));
        end
      end
      step();
      idle();
      n_checks++;
      if (iss_valid !== 1'b1 || iss_T !== 3'(c) || iss_V1 !== 32'h100 + 32'(c)) begin
        n_fail++;
        $display("FAIL ov_issue_%0d got v=%b T=%0d V1=%0h expected v=1 T=%0d V1=%0h", c, iss_valid, iss_T, iss_V1, c, 32'h100 + 32'(c));
      end
    end
    step();
    iss_ready = 1'b0;
    n_checks++; if (iss_valid !== 1'b0 || free_cnt !== 4'd8) begin n_fail++; $display("FAIL ov_drain got v=%b cnt=%0d expected 0/8", iss_valid, free_cnt); end
  endtask

  task automatic test_hold_priority();
    logic [2:0] first_t, second_t;
`ifdef RS_AGE_SELECT_EN
    first_t = 3'd5; second_t = 3'd2;
`else
    first_t = 3'd2; second_t = 3'd5;
`endif
    iss_ready = 1'b1;
    set_slot(0, 64'h40, 3'd4, 3'd0, 1'b1, 32'd4, 3'd0, 1'b1, 32'd4);
    set_slot(1, 64'h50, 3'd5, 3'd6, 1'b0, 32'd0, 3'd0, 1'b1, 32'd5);
    step();
    idle();
    n_checks++; if (iss_T !== 3'd4 || iss_valid !== 1'b1) begin n_fail++; $display("FAIL hp_first got v=%b T=%0d expected v=1 T=4", iss_valid, iss_T); end
    step();
    iss_ready = 1'b0;
    // newer ready op lands in entry 0 while the older one in entry 1 wakes
    set_slot(0, 64'h20, 3'd2, 3'd0, 1'b1, 32'd2, 3'd0, 1'b1, 32'd2);
    set_cdb(0, 3'd6, 32'h66);
    step();
    idle();
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (iss_valid !== 1'b1 || iss_T !== first_t) begin
        n_fail++;
        $display("FAIL hp_hold_%0d got v=%b T=%0d expected v=1 T=%0d", i, iss_valid, iss_T, first_t);
      end
      step();
    end
    iss_ready = 1'b1;
    step();
    n_checks++; if (iss_valid !== 1'b1 || iss_T !== second_t) begin n_fail++; $display("FAIL hp_second got v=%b T=%0d expected v=1 T=%0d", iss_valid, iss_T, second_t); end
    step();
    iss_ready = 1'b0;
    n_checks++; if (iss_valid !== 1'b0 || free_cnt !== 4'd8) begin n_fail++; $display("FAIL hp_drain got v=%b cnt=%0d expected 0/8", iss_valid, free_cnt); end
  endtask

  task automatic test_clear();
    set_slot(0, 64'h1, 3'd1, 3'd3, 1'b0, 32'd0, 3'd0, 1'b1, 32'd0);
    set_slot(1, 64'h2, 3'd2, 3'd0, 1'b1, 32'd0, 3'd0, 1'b1, 32'd0);
    step();
    idle();
    n_checks++; if (iss_valid !== 1'b1 || free_cnt !== 4'd6) begin n_fail++; $display("FAIL clr_setup got v=%b cnt=%0d expected 1/6", iss_valid, free_cnt); end
    clear = 1'b1;
    iss_ready = 1'b1;
    set_cdb(0, 3'd3, 32'h9);
    step();
    clear = 1'b0;
    iss_ready = 1'b0;
    idle();
    n_checks++; if (free_cnt !== 4'd8 || iss_valid !== 1'b0) begin n_fail++; $display("FAIL clr_state got cnt=%0d v=%b expected 8/0", free_cnt, iss_valid); end
    step();
    n_checks++; if (iss_valid !== 1'b0 || dp_overflow !== 1'b0) begin n_fail++; $display("FAIL clr_no_wake got v=%b ovf=%b expected 0/0", iss_valid, dp_overflow); end
    set_slot(0, 64'h6, 3'd6, 3'd0, 1'b1, 32'd8, 3'd0, 1'b1, 32'd9);
    step();
    idle();
    n_checks++; if (iss_valid !== 1'b1 || iss_T !== 3'd6) begin n_fail++; $display("FAIL clr_reuse got v=%b T=%0d expected 1/6", iss_valid, iss_T); end
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; iss_ready = 1'b0;
    dp_valid = '0; dp_payload = '0; dp_T = '0; dp_T1 = '0; dp_T2 = '0;
    dp_rdy1 = '0; dp_rdy2 = '0; dp_V1 = '0; dp_V2 = '0;
    cdb_valid = '0; cdb_tag = '0; cdb_value = '0;
    test_reset();
    test_ready_dispatch();
    test_cdb_wakeup();
    test_dispatch_capture();
    test_overflow();
    test_hold_priority();
    test_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
